dual_bram_rdw: RTL

Parametrised successor to the dart dual-port block RAM. It adds byte-lane write enables, a selectable registered read latency (1 or 2), a defined read-during-write policy, and a self-clearing initialisation sweep after reset. It sits between the datapath write stage and downstream read consumers wherever the design needs a 1W/1R table with known contents after reset. It also supports read-modify-write through the write-address readback port.

---
 rtl/dual_bram_rdw.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dual_bram_rdw.sv
// dual_bram_rdw
// One-write / one-read block RAM with per-lane write enables, a registered
// read latency of 1 or 2 enabled cycles, a selectable read-during-write
// result, and a zero-fill sweep after every reset so contents are known
// before the first access is accepted.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   enable      global clock enable (the clear sweep ignores it)
//   wen         write request
//   wbe         per-lane write enable, lane i = din[i*LANE_W +: LANE_W]
//   waddr       write address (also the read-modify-write readback address)
//   raddr       read address
//   din         write data
//   dout        read data for raddr
//   wdout       contents of waddr before that cycle's write
//   dout_valid  dout/wdout hold data from an accepted access
//   init_done   clear sweep finished, accesses are accepted
module dual_bram_rdw #(
  parameter int WIDTH      = 36,
  parameter int LOG_DEP    = 6,
  parameter int LANE_W     = 9,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      wen,
  input  logic [WIDTH/LANE_W-1:0]   wbe,
  input  logic [LOG_DEP-1:0]        waddr,
  input  logic [LOG_DEP-1:0]        raddr,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [WIDTH-1:0]          wdout,
  output logic                      dout_valid,
  output logic                      init_done
);

  localparam int NLANE = WIDTH / LANE_W;
  localparam int DEPTH = 1 << LOG_DEP;

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("dual_bram_rdw: RD_LATENCY must be 1 or 2");
  end
  if ((WIDTH % LANE_W) != 0) begin : g_bad_lanes
    $error("dual_bram_rdw: WIDTH must be a multiple of LANE_W");
  end

  typedef enum logic [0:0] {CLEAR, READY} state_t;

  state_t             state;
  state_t             next_state;
  logic [LOG_DEP-1:0] clr_cnt;
  logic               accept;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   old_w;
  logic [WIDTH-1:0]   merged;
  logic [WIDTH-1:0]   rd_word;

  assign accept = enable & init_done;

  // The sweep ends on the cycle that clears the last address.
  always_comb begin
    next_state = state;
    if (state == CLEAR && clr_cnt == LOG_DEP'(DEPTH - 1)) begin
      next_state = READY;
    end
  end

  // init_done is a dedicated flop so it rises on the final clear edge
  // without any decode between the state register and the port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      init_done <= 1'b0;
      clr_cnt   <= '0;
    end else begin
      state     <= next_state;
      init_done <= (next_state == READY);
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Both read ports see the array before this cycle's write. The merged
  // word is what gets stored and, in new-data mode, what a colliding read
  // returns.
  always_comb begin
    old_w   = mem[waddr];
    merged  = old_w;
    for (int i = 0; i < NLANE; i++) begin
      if (wbe[i]) begin
        merged[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
      end
    end
    rd_word = mem[raddr];
    if (RDW_MODE == 1 && wen && raddr == waddr) begin
      rd_word = merged;
    end
  end

  // Storage has no reset so it maps onto block RAM; the sweep provides
  // the known contents instead.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (accept && wen) begin
      mem[waddr] <= merged;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] s1_dout;
    logic [WIDTH-1:0] s1_wdout;
    logic             s1_valid;

    // Data is captured at acceptance, so later writes never reach a read
    // that is already in flight; both stages advance only on enable.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1_dout    <= '0;
        s1_wdout   <= '0;
        s1_valid   <= 1'b0;
        dout       <= '0;
        wdout      <= '0;
        dout_valid <= 1'b0;
      end else if (accept) begin
        s1_dout    <= rd_word;
        s1_wdout   <= old_w;
        s1_valid   <= 1'b1;
        dout       <= s1_dout;
        wdout      <= s1_wdout;
        dout_valid <= s1_valid;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        dout       <= '0;
        wdout      <= '0;
        dout_valid <= 1'b0;
      end else if (accept) begin
        dout       <= rd_word;
        wdout      <= old_w;
        dout_valid <= 1'b1;
      end
    end
  end

endmodule
